// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bundle of the program-load, control and issue signals of
//                instr_fetch.
//                The slave modport is the fetch unit.
//                The master modport is the loader/controller side and
//                consumes the issue.
//  Ports       : load_en/load_addr/load_data  program-memory write
//                start/stall                  execution control
//                opcode/operand/valid         issued instruction
//                pc/halted/issue_cnt          status
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic       stall;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       valid;
  logic [3:0] pc;
  logic       halted;
  logic [7:0] issue_cnt;

  modport master (
    output load_en, load_addr, load_data, start, stall,
    input  opcode, operand, valid, pc, halted, issue_cnt
  );

  modport slave (
    input  load_en, load_addr, load_data, start, stall,
    output opcode, operand, valid, pc, halted, issue_cnt
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch/issue unit with a 16 x 8 program memory.
//                Each word has the form {opcode[7:4], operand[3:0]}.
//                Opcode 4'hE jumps to the operand address.
//                Opcode 4'hF halts.
//                Every other opcode is issued downstream.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - instr_fetch_if.slave (load, control, issue, status)
//  Parameters  : START_PC - PC loaded on reset and on every start
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [3:0] START_PC = 4'h0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  instr_fetch_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0] C_OP_JMP  = 4'hE;
  localparam logic [3:0] C_OP_HALT = 4'hF;

  logic [1:0] r_state;
  logic [3:0] r_pc;
  logic [3:0] r_opcode;
  logic [3:0] r_operand;
  logic       r_valid;
  logic [7:0] r_issue_cnt;
  logic [7:0] r_mem [16];

  logic [7:0] w_word;
  logic       w_load_ok;

  assign w_word    = r_mem[r_pc];
  // The memory may only be written while nothing is being fetched.
  assign w_load_ok = bus.load_en && (r_state != ST_RUN);

  // Program memory. Reset clears every word, so it sits in flops rather
  // than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_load_ok) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= START_PC;
      r_opcode    <= 4'h0;
      r_operand   <= 4'h0;
      r_valid     <= 1'b0;
      r_issue_cnt <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          // A load on the same edge lands in memory first. A word written
          // to START_PC is therefore the one fetched on the next edge.
          if (bus.start) begin
            r_state     <= ST_RUN;
            r_pc        <= START_PC;
            r_issue_cnt <= 8'h00;
            r_valid     <= 1'b0;
          end
        end
        ST_RUN: begin
          // A stall freezes everything, including a pending JMP or HALT.
          if (!bus.stall) begin
            case (w_word[7:4])
              C_OP_JMP: begin
                r_pc    <= w_word[3:0];
                r_valid <= 1'b0;
              end
              C_OP_HALT: begin
                r_state <= ST_HALT;
                r_valid <= 1'b0;
              end
              default: begin
                r_opcode  <= w_word[7:4];
                r_operand <= w_word[3:0];
                r_valid   <= 1'b1;
                r_pc      <= r_pc + 4'd1;  // wraps 15 -> 0
                if (r_issue_cnt != 8'hFF) begin
                  r_issue_cnt <= r_issue_cnt + 8'd1;
                end
              end
            endcase
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.opcode    = r_opcode;
  assign bus.operand   = r_operand;
  assign bus.valid     = r_valid;
  assign bus.pc        = r_pc;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.issue_cnt = r_issue_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch.
//                Each step is checked against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  instr_fetch_if bus ();

  instr_fetch #(.START_PC(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = 4'h0;
    bus.load_data = 8'h00;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    #2;
    // Reset values before any clock edge.
    check("rst_pc",     {28'd0, bus.pc},        32'h0);
    check("rst_valid",  {31'd0, bus.valid},     32'h0);
    check("rst_halted", {31'd0, bus.halted},    32'h0);
    check("rst_cnt",    {24'd0, bus.issue_cnt}, 32'h0);
    check("rst_opcode", {28'd0, bus.opcode},    32'h0);
    #4 rst_n = 1'b1;
    tick();

    // Basic program: three issues, then HALT.
    load(4'h0, 8'h12); load(4'h1, 8'h34); load(4'h2, 8'h56); load(4'h3, 8'hF0);
    do_start();                                        // edge 1
    check("e1_valid", {31'd0, bus.valid}, 32'h0);
    check("e1_pc",    {28'd0, bus.pc},    32'h0);
    tick();                                            // edge 2
    check("e2_issue", {27'd0, bus.valid, bus.opcode, bus.operand}, 32'h112);
    tick();                                            // edge 3
    check("e3_issue", {27'd0, bus.valid, bus.opcode, bus.operand}, 32'h134);
    tick();                                            // edge 4
    check("e4_issue", {27'd0, bus.valid, bus.opcode, bus.operand}, 32'h156);
    tick();                                            // edge 5
    check("e5_halted", {31'd0, bus.halted},    32'h1);
    check("e5_valid",  {31'd0, bus.valid},     32'h0);
    check("e5_cnt",    {24'd0, bus.issue_cnt}, 32'd3);
    check("e5_pc",     {28'd0, bus.pc},        32'h3);
    check("halt_keep_op", {24'd0, bus.opcode, bus.operand}, 32'h56);

    // Stall for 3 cycles after the first issue.
    do_start();
    tick();
    bus.stall = 1'b1;
    tick(); tick(); tick();
    check("stall_op",  {24'd0, bus.opcode, bus.operand}, 32'h12);
    check("stall_pc",  {28'd0, bus.pc},        32'h1);
    check("stall_vld", {31'd0, bus.valid},     32'h1);
    check("stall_cnt", {24'd0, bus.issue_cnt}, 32'd1);
    bus.stall = 1'b0;
    tick();
    check("unstall_op",  {24'd0, bus.opcode, bus.operand}, 32'h34);
    check("unstall_cnt", {24'd0, bus.issue_cnt}, 32'd2);
    tick(); tick();
    check("stall_run_halt", {31'd0, bus.halted}, 32'h1);

    // A load during RUN is ignored.
    do_start();
    tick();                                  // issue 1/2, pc=1
    bus.load_en = 1'b1; bus.load_addr = 4'h2; bus.load_data = 8'hF0;
    tick();                                  // issue 3/4, write ignored
    bus.load_en = 1'b0;
    tick();                                  // mem[2] still 8'h56
    check("runload_ignored", {27'd0, bus.valid, bus.opcode, bus.operand}, 32'h156);
    tick();
    check("runload_halt", {31'd0, bus.halted}, 32'h1);

    // In HALT, a load together with start: the new word is fetched.
    bus.load_en = 1'b1; bus.load_addr = 4'h2; bus.load_data = 8'hF0;
    bus.start = 1'b1;
    tick();
    bus.load_en = 1'b0; bus.start = 1'b0;
    tick(); tick(); tick();                  // 1/2, 3/4, HALT at pc 2
    check("haltload_halted", {31'd0, bus.halted},    32'h1);
    check("haltload_cnt",    {24'd0, bus.issue_cnt}, 32'd2);
    check("haltload_pc",     {28'd0, bus.pc},        32'h2);

    // Start and a write to START_PC on the same edge.
    bus.load_en = 1'b1; bus.load_addr = 4'h0; bus.load_data = 8'h9C;
    bus.start = 1'b1;
    tick();
    bus.load_en = 1'b0; bus.start = 1'b0;
    tick();
    check("same_edge_load", {27'd0, bus.valid, bus.opcode, bus.operand}, 32'h19C);
    tick(); tick();                          // 3/4, then HALT at pc 2

    // JMP to 5, then issue 7/A, then HALT.
    load(4'h0, 8'hE5); load(4'h5, 8'h7A); load(4'h6, 8'hF0);
    do_start();
    tick();
    check("jmp_valid", {31'd0, bus.valid}, 32'h0);
    check("jmp_pc",    {28'd0, bus.pc},    32'h5);
    tick();
    check("jmp_issue", {27'd0, bus.valid, bus.opcode, bus.operand}, 32'h17A);
    tick();
    check("jmp_halt", {31'd0, bus.halted}, 32'h1);

    // Asynchronous reset in the middle of RUN.
    do_start();
    tick(); tick();                          // jmp, issue 7/A
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.valid},     32'h0);
    check("arst_pc",    {28'd0, bus.pc},        32'h0);
    check("arst_cnt",   {24'd0, bus.issue_cnt}, 32'h0);
    rst_n = 1'b1;
    tick(); tick();
    check("arst_idle", {27'd0, bus.halted, bus.valid, bus.pc}, 32'h0);
    do_start();
    tick();                                  // mem[0] cleared -> issue 0/0
    check("arst_mem0", {27'd0, bus.valid, bus.opcode, bus.operand}, 32'h100);
    check("arst_mem0_pc", {28'd0, bus.pc}, 32'h1);

    // Self-targeted JMP loops without issuing.
    do_reset();
    load(4'h0, 8'hE0);
    do_start();
    tick(); tick(); tick();
    check("selfjmp", {27'd0, bus.halted, bus.valid, bus.pc}, 32'h0);

    // PC wrap and issue-counter saturation.
    do_reset();
    for (int i = 0; i < 16; i++) load(i[3:0], 8'h11);
    do_start();
    for (int i = 0; i < 16; i++) tick();
    check("wrap_pc",  {28'd0, bus.pc},        32'h0);
    check("wrap_cnt", {24'd0, bus.issue_cnt}, 32'd16);
    for (int i = 0; i < 4; i++) tick();
    check("cnt20",    {24'd0, bus.issue_cnt}, 32'd20);
    check("pc20",     {28'd0, bus.pc},        32'h4);
    bus.start = 1'b1;                        // ignored in RUN
    tick();
    bus.start = 1'b0;
    check("start_in_run_cnt", {24'd0, bus.issue_cnt}, 32'd21);
    check("start_in_run_pc",  {28'd0, bus.pc},        32'h5);
    for (int i = 0; i < 259; i++) tick();
    check("sat_cnt", {24'd0, bus.issue_cnt}, 32'hFF);
    check("sat_pc",  {28'd0, bus.pc},        32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
